cb_pingpong_buf: RTL and testbench

Downstream stage of the code-block segmentation unit. It captures the segmented byte stream (cb_data with its start, filling and crc flags and cb_size) into one of two code-block banks. It then presents each completed block to the turbo encoder / interleaver through a byte-serial read handshake. Double buffering lets segmentation of block n+1 overlap encoding of block n.

---
 rtl/cb_pkg.sv | 20 ++
 rtl/cb_bank_ram.sv | 32 +++
 rtl/cb_pingpong_buf.sv | 205 ++++++++++++++++++++
 tb/tb_cb_pingpong_buf.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cb_pkg.sv
// Shared constants and types for the code-block segmentation path.
// The upstream segmentation control FSM and the ping-pong buffer both import this.
package cb_pkg;

    localparam int DW            = 8;
    localparam int K_SMALL_BYTES = 132;   // K = 1056 bits
    localparam int K_LARGE_BYTES = 768;   // K = 6144 bits
    localparam int AW            = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    function automatic logic [AW-1:0] cb_len(input logic size);
        return size ? AW'(K_LARGE_BYTES) : AW'(K_SMALL_BYTES);
    endfunction

endpackage

// File: rtl/cb_bank_ram.sv
// Simple dual-port synchronous RAM holding both code-block banks.
// One write port, one read port with a registered (1-cycle) output.
module cb_bank_ram #(
    parameter int DW = cb_pkg::DW,
    parameter int AW = cb_pkg::AW
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic [DW:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW:0]   rd_addr,
    output logic [DW:0]   rd_data
);

    localparam int DEPTH = 2 ** (AW + 1);

    logic [DW:0] mem_q [DEPTH];
    logic [DW:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cb_pingpong_buf.sv
// Double-buffered code-block store between segmentation and the turbo encoder.
// Blocks are written byte-serially into one bank while the other is read out.
//
//   state | meaning
//   IDLE  | waiting for a start byte into wr_bank
//   FILL  | storing bytes of the current block at wr_idx
//   DROP  | block rejected (both banks full), discarding until next start
module cb_pingpong_buf #(
    parameter int DW            = cb_pkg::DW,
    parameter int K_SMALL_BYTES = cb_pkg::K_SMALL_BYTES,
    parameter int K_LARGE_BYTES = cb_pkg::K_LARGE_BYTES,
    parameter int AW            = cb_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] cb_data,
    input  logic          cb_size,
    input  logic          start,
    input  logic          filling,
    input  logic          crc,
    output logic          blk_avail,
    output logic          rd_size,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_fill,
    output logic          rd_last,
    output logic          err_overflow,
    output logic          err_abort
);

    import cb_pkg::*;

    localparam logic [AW-1:0] LAST_SMALL = AW'(K_SMALL_BYTES - 1);
    localparam logic [AW-1:0] LAST_LARGE = AW'(K_LARGE_BYTES - 1);

    function automatic logic [AW-1:0] last_idx(input logic size);
        return size ? LAST_LARGE : LAST_SMALL;
    endfunction

    wr_state_t     wr_state_q, wr_state_d;
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    size_q, size_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_abort_q, err_abort_d;

    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_idx;
    logic [AW:0]   ram_wr_addr;
    logic [DW:0]   ram_wr_data;
    logic          rd_fire;
    logic [AW:0]   ram_rd_addr;
    logic [DW:0]   ram_rd_data;
    logic          wr_done;
    logic          rd_done;

    // CRC bytes are stored like any other byte; the flag itself is not kept.
    logic unused_crc;
    assign unused_crc = crc;

    always_comb begin
        wr_state_d     = wr_state_q;
        wr_bank_d      = wr_bank_q;
        wr_idx_d       = wr_idx_q;
        size_d         = size_q;
        err_overflow_d = err_overflow_q;
        err_abort_d    = err_abort_q;
        ram_wr_en      = 1'b0;
        ram_wr_idx     = wr_idx_q;
        wr_done        = 1'b0;

        unique case (wr_state_q)
            IDLE, DROP: begin
                if (in_valid && start) begin
                    if (full_q[wr_bank_q]) begin
                        err_overflow_d = 1'b1;
                        wr_state_d     = DROP;
                    end else begin
                        ram_wr_en         = 1'b1;
                        ram_wr_idx        = '0;
                        size_d[wr_bank_q] = cb_size;
                        wr_idx_d          = AW'(1);
                        wr_state_d        = FILL;
                    end
                end
            end
            FILL: begin
                if (in_valid) begin
                    ram_wr_en = 1'b1;
                    if (start) begin
                        // Restart in the same bank; the partial block is overwritten.
                        err_abort_d       = 1'b1;
                        ram_wr_idx        = '0;
                        size_d[wr_bank_q] = cb_size;
                        wr_idx_d          = AW'(1);
                    end else if (wr_idx_q == last_idx(size_q[wr_bank_q])) begin
                        wr_done    = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                        wr_idx_d   = '0;
                        wr_state_d = IDLE;
                    end else begin
                        wr_idx_d = wr_idx_q + AW'(1);
                    end
                end
            end
            default: begin
                wr_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_bank_d  = rd_bank_q;
        rd_idx_d   = rd_idx_q;
        rd_done    = 1'b0;
        rd_last_d  = 1'b0;
        rd_fire    = rd_req && full_q[rd_bank_q];
        rd_valid_d = rd_fire;
        if (rd_fire) begin
            if (rd_idx_q == last_idx(size_q[rd_bank_q])) begin
                rd_last_d = 1'b1;
                rd_done   = 1'b1;
                rd_bank_d = ~rd_bank_q;
                rd_idx_d  = '0;
            end else begin
                rd_idx_d = rd_idx_q + AW'(1);
            end
        end
    end

    // Writer only completes into a free bank and reader only frees a full one,
    // so both updates always target different bits.
    always_comb begin
        full_d = full_q;
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q     <= IDLE;
            wr_bank_q      <= 1'b0;
            wr_idx_q       <= '0;
            full_q         <= '0;
            size_q         <= '0;
            rd_bank_q      <= 1'b0;
            rd_idx_q       <= '0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            err_overflow_q <= 1'b0;
            err_abort_q    <= 1'b0;
        end else begin
            wr_state_q     <= wr_state_d;
            wr_bank_q      <= wr_bank_d;
            wr_idx_q       <= wr_idx_d;
            full_q         <= full_d;
            size_q         <= size_d;
            rd_bank_q      <= rd_bank_d;
            rd_idx_q       <= rd_idx_d;
            rd_valid_q     <= rd_valid_d;
            rd_last_q      <= rd_last_d;
            err_overflow_q <= err_overflow_d;
            err_abort_q    <= err_abort_d;
        end
    end

    assign ram_wr_addr = {wr_bank_q, ram_wr_idx};
    assign ram_wr_data = {filling, cb_data};
    assign ram_rd_addr = {rd_bank_q, rd_idx_q};

    cb_bank_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_en   (rd_fire),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    // RAM output register is not reset, so gate data with the valid flop.
    assign rd_data      = rd_valid_q ? ram_rd_data[DW-1:0] : '0;
    assign rd_fill      = rd_valid_q & ram_rd_data[DW];
    assign rd_valid     = rd_valid_q;
    assign rd_last      = rd_last_q;
    assign blk_avail    = full_q[rd_bank_q];
    assign rd_size      = size_q[rd_bank_q];
    assign err_overflow = err_overflow_q;
    assign err_abort    = err_abort_q;

endmodule

// File: tb/tb_cb_pingpong_buf.sv
// Directed bench for cb_pingpong_buf: small/large blocks, ping-pong overflow,
// abort, concurrent last write/read, and reset in the middle of a read.
module tb_cb_pingpong_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] cb_data;
    logic       cb_size;
    logic       start;
    logic       filling;
    logic       crc;
    logic       blk_avail;
    logic       rd_size;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_fill;
    logic       rd_last;
    logic       err_overflow;
    logic       err_abort;

    int total = 0;
    int bad   = 0;

    cb_pingpong_buf dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .cb_data      (cb_data),
        .cb_size      (cb_size),
        .start        (start),
        .filling      (filling),
        .crc          (crc),
        .blk_avail    (blk_avail),
        .rd_size      (rd_size),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_fill      (rd_fill),
        .rd_last      (rd_last),
        .err_overflow (err_overflow),
        .err_abort    (err_abort)
    );

    always #5 clk = ~clk;

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_bytes(input logic sz, input int from, input int to,
                               input int base, input int nfill);
        for (int i = from; i < to; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            start    = (i == 0);
            cb_size  = sz;
            cb_data  = 8'(base + i);
            filling  = (i < nfill);
            crc      = (i >= to - 3);
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        filling  = 1'b0;
        crc      = 1'b0;
        cb_data  = 8'h00;
    endtask

    // Issues n requests back to back; checks each returned byte one cycle later.
    task automatic read_bytes(input string tag, input int n, input int blen,
                              input int base, input int nfill);
        logic [10:0] obs_v;
        logic [10:0] exp_v;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                obs_v = {rd_valid, rd_last, rd_fill, rd_data};
                exp_v = {1'b1, ((i - 1) == (blen - 1)), ((i - 1) < nfill), 8'(base + i - 1)};
                check(tag, 32'(obs_v), 32'(exp_v));
            end
            rd_req = (i < n);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        cb_data  = 8'h00;
        cb_size  = 1'b0;
        start    = 1'b0;
        filling  = 1'b0;
        crc      = 1'b0;
        rd_req   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_avail", 32'(blk_avail), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data",  32'(rd_data), 32'd0);
        check("rst_flags", 32'({rd_fill, rd_last, rd_size}), 32'd0);
        check("rst_errs",  32'({err_overflow, err_abort}), 32'd0);
        reset = 1'b0;

        // byte without start while idle is ignored
        @(negedge clk);
        in_valid = 1'b1;
        cb_data  = 8'hEE;
        idle_in();
        check("idle_ignore", 32'({blk_avail, err_overflow, err_abort}), 32'd0);

        // small block with a stall before the last byte
        drive_bytes(1'b0, 0, 131, 8'h00, 5);
        idle_in();
        check("small_avail_pre", 32'(blk_avail), 32'd0);
        drive_bytes(1'b0, 131, 132, 8'h00, 5);
        idle_in();
        check("small_avail", 32'(blk_avail), 32'd1);
        check("small_size", 32'(rd_size), 32'd0);
        read_bytes("small_rd", 132, 132, 8'h00, 5);
        check("small_avail_post", 32'(blk_avail), 32'd0);
        @(negedge clk);
        rd_req = 1'b1;
        @(negedge clk);
        check("req_empty", 32'(rd_valid), 32'd0);
        rd_req = 1'b0;

        // large block in bank 1
        drive_bytes(1'b1, 0, 768, 8'h10, 0);
        idle_in();
        check("large_avail", 32'(blk_avail), 32'd1);
        check("large_size", 32'(rd_size), 32'd1);
        read_bytes("large_rd", 768, 768, 8'h10, 0);
        check("large_avail_post", 32'(blk_avail), 32'd0);

        // ping-pong: A, B back to back, third block overflows
        drive_bytes(1'b0, 0, 132, 8'h20, 3);
        drive_bytes(1'b1, 0, 768, 8'h40, 0);
        check("ovf_pre", 32'(err_overflow), 32'd0);
        drive_bytes(1'b0, 0, 132, 8'h99, 0);
        idle_in();
        check("ovf_set", 32'(err_overflow), 32'd1);
        check("pp_avail_a", 32'({blk_avail, rd_size}), 32'b10);
        fork
            read_bytes("pp_rd_a", 132, 132, 8'h20, 3);
            begin
                // start lands the cycle right after bank 0 is freed
                repeat (132) @(negedge clk);
                drive_bytes(1'b0, 0, 132, 8'h60, 1);
                idle_in();
            end
        join
        check("pp_avail_b", 32'({blk_avail, rd_size}), 32'b11);
        read_bytes("pp_rd_b", 768, 768, 8'h40, 0);
        check("pp_avail_c", 32'({blk_avail, rd_size}), 32'b10);
        read_bytes("pp_rd_c", 132, 132, 8'h60, 1);
        check("pp_avail_post", 32'(blk_avail), 32'd0);

        // abort: partial large block replaced by a new small block
        check("abort_pre", 32'(err_abort), 32'd0);
        drive_bytes(1'b1, 0, 50, 8'h70, 0);
        drive_bytes(1'b0, 0, 132, 8'h80, 2);
        idle_in();
        check("abort_set", 32'(err_abort), 32'd1);
        check("abort_avail", 32'({blk_avail, rd_size}), 32'b10);
        read_bytes("abort_rd", 132, 132, 8'h80, 2);
        check("abort_avail_post", 32'(blk_avail), 32'd0);

        // concurrent: last write into bank 1 and last read of bank 0 coincide
        drive_bytes(1'b0, 0, 132, 8'hA0, 0);
        idle_in();
        fork
            begin
                repeat (636) @(negedge clk);
                read_bytes("cc_rd_d", 132, 132, 8'hA0, 0);
            end
            begin
                drive_bytes(1'b1, 0, 768, 8'hB0, 4);
                idle_in();
            end
        join
        check("cc_avail", 32'({blk_avail, rd_size}), 32'b11);
        read_bytes("cc_rd_e", 768, 768, 8'hB0, 4);
        check("cc_avail_post", 32'(blk_avail), 32'd0);

        // reset in the middle of a read
        drive_bytes(1'b0, 0, 132, 8'h05, 0);
        idle_in();
        read_bytes("mid_rd", 40, 132, 8'h05, 0);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_avail", 32'(blk_avail), 32'd0);
        check("mrst_valid", 32'({rd_valid, rd_data}), 32'd0);
        check("mrst_errs", 32'({err_overflow, err_abort}), 32'd0);
        reset = 1'b0;
        drive_bytes(1'b0, 0, 132, 8'h30, 5);
        idle_in();
        check("fresh_avail", 32'({blk_avail, rd_size}), 32'b10);
        read_bytes("fresh_rd", 132, 132, 8'h30, 5);
        check("fresh_avail_post", 32'(blk_avail), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
